// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: size codes, split FSM states
// and the default for misaligned-access splitting.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam bit MISALIGN_EN_DEFAULT = 1'b1;

    typedef enum logic [0:0] {
        StIdle,
        StSplit
    } split_state_t;

endpackage

// File: rtl/load_extend.sv
// Assembles a split load from the buffered low bytes and the final byte, then
// sign- or zero-extends halfwords to 32 bits.
module load_extend (
    input  logic        is_half,
    input  logic        is_unsigned,
    input  logic [23:0] low_bytes,
    input  logic [7:0]  top_byte,
    output logic [31:0] data
);

    logic [15:0] half;

    // Halfwords use only the first buffered byte; words use all three.
    always_comb begin
        half = {top_byte, low_bytes[7:0]};
        if (is_half) begin
            data = is_unsigned ? {16'h0000, half} : {{16{half[15]}}, half};
        end else begin
            data = {top_byte, low_bytes};
        end
    end

endmodule

// File: rtl/misaligned_access_unit.sv
// Sits between the core's load/store port and the data memory. Aligned accesses
// pass straight through; misaligned halfwords/words are serialised into byte ops.
module misaligned_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter bit          MISALIGN_EN = MISALIGN_EN_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    output logic              mem_sw,
    output logic              mem_sh,
    output logic              mem_sb,
    output logic              mem_lw,
    output logic              mem_lh,
    output logic              mem_lhu,
    output logic              mem_lb,
    output logic              mem_lbu,
    input  logic [31:0]       mem_rdata
);

    split_state_t state_q;
    logic [1:0]   count_q;
    logic [23:0]  buffer_q;

    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        splitting;
    logic [1:0]  byte_idx;
    logic [1:0]  last_idx;
    logic        last_byte;
    logic [31:0] split_rdata;

    // Size code 11 behaves as a word.
    assign is_half    = (req_size == SIZE_HALF);
    assign is_word    = req_size[1];
    assign misaligned = MISALIGN_EN &&
                        ((is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00)));
    // Once in StSplit the core holds the request stable, so no need to re-test alignment.
    assign splitting  = (state_q == StSplit) || misaligned;
    assign byte_idx   = (state_q == StSplit) ? count_q : 2'd0;
    assign last_idx   = is_half ? 2'd1 : 2'd3;
    assign last_byte  = (byte_idx == last_idx);

    load_extend u_load_extend (
        .is_half     (is_half),
        .is_unsigned (req_unsigned),
        .low_bytes   (buffer_q),
        .top_byte    (mem_rdata[7:0]),
        .data        (split_rdata)
    );

    // Split sequencing: byte counter and capture of the low load bytes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            count_q  <= 2'd0;
            buffer_q <= 24'h000000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && misaligned) begin
                        state_q <= StSplit;
                        count_q <= 2'd1;
                        if (!req_we) begin
                            buffer_q[7:0] <= mem_rdata[7:0];
                        end
                    end
                end
                StSplit: begin
                    if (!req_valid || last_byte) begin
                        // Abort (request withdrawn) or completion.
                        state_q <= StIdle;
                        count_q <= 2'd0;
                    end else begin
                        count_q <= count_q + 2'd1;
                        if (!req_we) begin
                            case (count_q)
                                2'd1:    buffer_q[15:8]  <= mem_rdata[7:0];
                                default: buffer_q[23:16] <= mem_rdata[7:0];
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Memory command and core response; everything is quiet while reset is held.
    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0000_0000;
        mem_addr   = req_addr;
        mem_wdata  = req_wdata;
        mem_write  = 1'b0;
        mem_sw     = 1'b0;
        mem_sh     = 1'b0;
        mem_sb     = 1'b0;
        mem_lw     = 1'b0;
        mem_lh     = 1'b0;
        mem_lhu    = 1'b0;
        mem_lb     = 1'b0;
        mem_lbu    = 1'b0;
        if (!reset && req_valid) begin
            if (splitting) begin
                mem_addr   = req_addr + ADDR_W'(byte_idx);
                mem_wdata  = {24'h000000, req_wdata[{byte_idx, 3'b000} +: 8]};
                mem_write  = req_we;
                mem_sb     = req_we;
                mem_lbu    = !req_we;
                stall      = !last_byte;
                resp_valid = last_byte;
                if (last_byte && !req_we) begin
                    resp_rdata = split_rdata;
                end
            end else begin
                mem_write  = req_we;
                resp_valid = 1'b1;
                resp_rdata = req_we ? 32'h0000_0000 : mem_rdata;
                case (req_size)
                    SIZE_BYTE: begin
                        mem_sb  = req_we;
                        mem_lb  = !req_we && !req_unsigned;
                        mem_lbu = !req_we && req_unsigned;
                    end
                    SIZE_HALF: begin
                        mem_sh  = req_we;
                        mem_lh  = !req_we && !req_unsigned;
                        mem_lhu = !req_we && req_unsigned;
                    end
                    default: begin
                        mem_sw = req_we;
                        mem_lw = !req_we;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_misaligned_access_unit.sv
// Self-checking bench: byte-array memory behind the DUT, and a separate byte-array
// reference image that predicts load data, latencies and final memory contents.
module tb_misaligned_access_unit;

    localparam int ADDR_W    = 12;
    localparam int MEM_BYTES = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_write;
    logic              mem_sw, mem_sh, mem_sb;
    logic              mem_lw, mem_lh, mem_lhu, mem_lb, mem_lbu;
    logic [31:0]       mem_rdata;

    logic [7:0] strobes;
    assign strobes = {mem_sw, mem_sh, mem_sb, mem_lw, mem_lh, mem_lhu, mem_lb, mem_lbu};

    always #5 clock = ~clock;

    misaligned_access_unit #(
        .ADDR_W      (ADDR_W),
        .MISALIGN_EN (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_sw       (mem_sw),
        .mem_sh       (mem_sh),
        .mem_sb       (mem_sb),
        .mem_lw       (mem_lw),
        .mem_lh       (mem_lh),
        .mem_lhu      (mem_lhu),
        .mem_lb       (mem_lb),
        .mem_lbu      (mem_lbu),
        .mem_rdata    (mem_rdata)
    );

    // Data memory driven by the DUT, plus a bench backdoor for clearing and preloading.
    logic [7:0]        mem     [MEM_BYTES];
    logic [7:0]        ref_mem [MEM_BYTES];
    logic              clear_en;
    logic              poke_en;
    logic [ADDR_W-1:0] poke_addr;
    logic [7:0]        poke_data;
    logic [7:0]        rb0, rb1, rb2, rb3;

    always_comb begin
        rb0 = mem[mem_addr];
        rb1 = mem[ADDR_W'(mem_addr + 1)];
        rb2 = mem[ADDR_W'(mem_addr + 2)];
        rb3 = mem[ADDR_W'(mem_addr + 3)];
        mem_rdata = 32'h0;
        if (mem_lw)       mem_rdata = {rb3, rb2, rb1, rb0};
        else if (mem_lh)  mem_rdata = {{16{rb1[7]}}, rb1, rb0};
        else if (mem_lhu) mem_rdata = {16'h0, rb1, rb0};
        else if (mem_lb)  mem_rdata = {{24{rb0[7]}}, rb0};
        else if (mem_lbu) mem_rdata = {24'h0, rb0};
    end

    always @(posedge clock) begin
        if (clear_en) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_write) begin
            if (mem_sb | mem_sh | mem_sw) mem[mem_addr] <= mem_wdata[7:0];
            if (mem_sh | mem_sw) mem[ADDR_W'(mem_addr + 1)] <= mem_wdata[15:8];
            if (mem_sw) begin
                mem[ADDR_W'(mem_addr + 2)] <= mem_wdata[23:16];
                mem[ADDR_W'(mem_addr + 3)] <= mem_wdata[31:24];
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic poke_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        for (int k = 0; k < 4; k++) begin
            poke_en   = 1'b1;
            poke_addr = ADDR_W'(addr + k);
            poke_data = data[8*k +: 8];
            ref_mem[ADDR_W'(addr + k)] = data[8*k +: 8];
            @(posedge clock);
            #1;
        end
        poke_en = 1'b0;
    endtask

    // One cycle with no request: everything quiet, address follows req_addr.
    task automatic idle_cycle(input string tag);
        logic [ADDR_W-1:0] a;
        a         = ADDR_W'($urandom);
        req_valid = 1'b0;
        req_addr  = a;
        @(negedge clock);
        check({tag, " idle stall"}, {31'h0, stall}, 32'h0);
        check({tag, " idle resp_valid"}, {31'h0, resp_valid}, 32'h0);
        check({tag, " idle strobes"}, {23'h0, mem_write, strobes}, 32'h0);
        check({tag, " idle mem_addr"}, 32'(mem_addr), 32'(a));
        @(posedge clock);
        #1;
    endtask

    // Issue one request; expectations come from byte-level rules applied to ref_mem.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] wdata, output logic [31:0] got);
        int                n;
        int                cycles;
        bit                mis;
        logic [31:0]       exp_data;
        logic [7:0]        exp_strobe;
        logic [ADDR_W-1:0] a;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis = (size == 2'd1 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
        cycles = mis ? n : 1;
        exp_data = 32'h0;
        for (int k = 0; k < n; k++) begin
            a = ADDR_W'(addr + k);
            if (we) ref_mem[a] = wdata[8*k +: 8];
            else exp_data = exp_data | (32'(ref_mem[a]) << (8 * k));
        end
        if (!we && !uns && n < 4 && exp_data[8*n-1]) exp_data = exp_data | (32'hFFFF_FFFF << (8 * n));
        if (mis) exp_strobe = we ? 8'b0010_0000 : 8'b0000_0001;
        else if (we) exp_strobe = (n == 1) ? 8'b0010_0000 : (n == 2) ? 8'b0100_0000 : 8'b1000_0000;
        else if (n == 1) exp_strobe = uns ? 8'b0000_0001 : 8'b0000_0010;
        else if (n == 2) exp_strobe = uns ? 8'b0000_0100 : 8'b0000_1000;
        else exp_strobe = 8'b0001_0000;

        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        got          = 32'h0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            a = ADDR_W'(addr + c);
            check({tag, " mem_addr"}, 32'(mem_addr), 32'(a));
            check({tag, " strobes"}, {23'h0, mem_write, strobes}, {23'h0, we, exp_strobe});
            check({tag, " stall"}, {31'h0, stall}, {31'h0, (c < cycles - 1)});
            check({tag, " resp_valid"}, {31'h0, resp_valid}, {31'h0, (c == cycles - 1)});
            if (mis && we) check({tag, " wbyte"}, 32'(mem_wdata[7:0]), 32'(wdata[8*c +: 8]));
            if (c == cycles - 1) begin
                got = resp_rdata;
                check({tag, " rdata"}, resp_rdata, we ? 32'h0 : exp_data);
            end
            @(posedge clock);
            #1;
        end
    endtask

    logic [31:0] got;
    int          bad;

    initial begin
        reset        = 1'b1;
        clear_en     = 1'b1;
        poke_en      = 1'b0;
        poke_addr    = '0;
        poke_data    = 8'h00;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = 32'h0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;

        // Reset behaviour
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b0;
        clear_en = 1'b0;
        @(negedge clock);
        check("reset stall", {31'h0, stall}, 32'h0);
        check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset mem_write", {31'h0, mem_write}, 32'h0);
        @(posedge clock);
        #1;

        poke_word(12'h100, 32'h4433_2211);
        poke_word(12'h104, 32'h8877_6655);
        poke_word(12'h108, 32'h0000_00C0);

        // Directed cases with fixed expected values
        run_req("lw100", 1'b0, 2'b10, 1'b0, 12'h100, 32'h0, got);
        check("lw100 value", got, 32'h4433_2211);
        run_req("lw102", 1'b0, 2'b10, 1'b0, 12'h102, 32'h0, got);
        check("lw102 value", got, 32'h6655_4433);
        run_req("lh107", 1'b0, 2'b01, 1'b0, 12'h107, 32'h0, got);
        check("lh107 value", got, 32'hFFFF_C088);
        run_req("lhu107", 1'b0, 2'b01, 1'b1, 12'h107, 32'h0, got);
        check("lhu107 value", got, 32'h0000_C088);
        idle_cycle("d1");

        run_req("swFFE", 1'b1, 2'b10, 1'b0, 12'hFFE, 32'hAABB_CCDD, got);
        run_req("lw000", 1'b0, 2'b10, 1'b0, 12'h000, 32'h0, got);
        check("lw000 value", got, 32'h0000_AABB);
        run_req("lwFFC", 1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0, got);
        check("lwFFC value", got, 32'hCCDD_0000);
        idle_cycle("d2");

        // Back-to-back: aligned load right after a split load
        run_req("b2b lw102", 1'b0, 2'b10, 1'b0, 12'h102, 32'h0, got);
        run_req("b2b lw104", 1'b0, 2'b10, 1'b0, 12'h104, 32'h0, got);
        check("b2b lw104 value", got, 32'h8877_6655);
        idle_cycle("d3");

        // Reset in the third cycle of a misaligned store
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 12'h201;
        req_wdata    = 32'h1122_3344;
        @(negedge clock);
        check("rst-split c1 stall", {31'h0, stall}, 32'h1);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rst-split c2 addr", 32'(mem_addr), 32'h202);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst-split c3 write", {31'h0, mem_write}, 32'h0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        check("rst-split after stall", {31'h0, stall}, 32'h0);
        check("rst-split after resp", {31'h0, resp_valid}, 32'h0);
        check("rst-split after write", {31'h0, mem_write}, 32'h0);
        check("rst-split m201", 32'(mem[12'h201]), 32'h44);
        check("rst-split m202", 32'(mem[12'h202]), 32'h33);
        check("rst-split m203", 32'(mem[12'h203]), 32'h00);
        check("rst-split m204", 32'(mem[12'h204]), 32'h00);
        ref_mem[12'h201] = 8'h44;
        ref_mem[12'h202] = 8'h33;
        @(posedge clock);
        #1;

        // Request withdrawn mid-split: no more memory ops, no response
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 12'h305;
        req_wdata = 32'h5566_7788;
        @(negedge clock);
        check("abort c1 stall", {31'h0, stall}, 32'h1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        check("abort strobes", {23'h0, mem_write, strobes}, 32'h0);
        check("abort resp_valid", {31'h0, resp_valid}, 32'h0);
        check("abort stall", {31'h0, stall}, 32'h0);
        ref_mem[12'h305] = 8'h88;
        @(posedge clock);
        #1;
        run_req("after abort lw304", 1'b0, 2'b10, 1'b0, 12'h304, 32'h0, got);
        check("after abort value", got, 32'h0000_8800);

        // Randomized traffic against the reference image
        for (int i = 0; i < 80; i++) begin
            logic [ADDR_W-1:0] ra;
            ra = (i % 4 == 0) ? ADDR_W'(12'hFF8 + $urandom_range(0, 7)) : ADDR_W'($urandom);
            run_req($sformatf("rand%0d", i), 1'($urandom), 2'($urandom), 1'($urandom), ra,
                    $urandom, got);
            if ($urandom_range(0, 3) == 0) idle_cycle($sformatf("rand%0d", i));
        end
        req_valid = 1'b0;
        @(posedge clock);
        #1;

        bad = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("memory image mismatching bytes", 32'(bad), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
